// File: rtl/samplerctrl.sv
// rtl/samplerctrl.sv - capture sequencer: start edge, settle warm-up, counted run, done pulse
// Optional idle-RUN watchdog is built when SAMPLERCTRL_TIMEOUT_EN is defined.
module samplerctrl #(
   parameter int CNT_W          = 16,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk_sampler,
   input  logic             rst_sampler_n_sync,
   input  logic             startsync_samplerctrl_start_r_sync,
   input  logic [CNT_W-1:0] cfg_num_samples,
   input  logic             abort,
   input  logic             sampler_valid,
   output logic             samplerctrl_sampler_en,
   output logic             sample_keep,
   output logic             busy,
   output logic             done,
   output logic             status_aborted,
   output logic             status_timeout,
   output logic [CNT_W-1:0] sample_cnt
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_RUN    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           r_state;
   state_t           w_next;
   logic             r_start_prev;
   logic             r_armed;
   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] r_settle_cnt;
   logic [CNT_W-1:0] r_sample_cnt;
   logic             r_en;
   logic             r_busy;
   logic             r_done;
   logic             r_aborted;
   logic             w_start_evt;
   logic             w_load;
   logic             w_final;
   logic             w_abort_set;
   logic             w_en_d;
   logic             w_busy_d;
   logic             w_done_d;
   logic [CNT_W-1:0] w_cnt_inc;

   // r_armed blocks a start level held through reset release from looking like an edge
   assign w_start_evt = startsync_samplerctrl_start_r_sync & ~r_start_prev & r_armed;
   assign w_load      = (r_state == S_IDLE) & w_start_evt;
   assign sample_keep = (r_state == S_RUN) & sampler_valid;
   assign w_cnt_inc   = r_sample_cnt + CNT_W'(1);
   assign w_final     = sample_keep & (w_cnt_inc == r_target);

`ifdef SAMPLERCTRL_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_idle_cnt;
   logic            r_timeout;
   logic            w_timeout;

   assign w_timeout = (r_state == S_RUN) & ~sample_keep & (r_idle_cnt == TO_LAST);

   always_ff @(posedge clk_sampler or negedge rst_sampler_n_sync) begin
      if (!rst_sampler_n_sync) begin
         r_idle_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         if ((r_state == S_RUN) && !sample_keep)
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
         else
            r_idle_cnt <= '0;
         if (w_load)
            r_timeout <= 1'b0;
         else if (w_timeout && !abort)
            r_timeout <= 1'b1;
      end
   end

   assign status_timeout = r_timeout;
`else
   assign status_timeout = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:
            if (w_start_evt)
               w_next = (cfg_num_samples != '0) ? S_SETTLE : S_DONE;
         S_SETTLE:
            if (abort)
               w_next = S_DONE;
            else if (r_settle_cnt == SETTLE_LAST)
               w_next = S_RUN;
         S_RUN:
            if (w_final || abort)
               w_next = S_DONE;
`ifdef SAMPLERCTRL_TIMEOUT_EN
            else if (w_timeout)
               w_next = S_DONE;
`endif
         S_DONE:
            w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   // Registered outputs are loaded from the state being entered
   always_comb begin
      w_en_d      = (w_next == S_SETTLE) || (w_next == S_RUN);
      w_busy_d    = (w_next != S_IDLE);
      w_done_d    = (r_state == S_DONE);
      w_abort_set = abort & ((r_state == S_SETTLE) | ((r_state == S_RUN) & ~w_final));
   end

   always_ff @(posedge clk_sampler or negedge rst_sampler_n_sync) begin
      if (!rst_sampler_n_sync) begin
         r_state      <= S_IDLE;
         r_start_prev <= 1'b0;
         r_armed      <= 1'b0;
         r_target     <= '0;
         r_settle_cnt <= '0;
         r_sample_cnt <= '0;
         r_en         <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_start_prev <= startsync_samplerctrl_start_r_sync;
         r_armed      <= r_armed | ~startsync_samplerctrl_start_r_sync;
         r_en         <= w_en_d;
         r_busy       <= w_busy_d;
         r_done       <= w_done_d;
         if (r_state == S_SETTLE)
            r_settle_cnt <= r_settle_cnt + CNT_W'(1);
         else
            r_settle_cnt <= '0;
         if (w_load) begin
            r_target     <= cfg_num_samples;
            r_sample_cnt <= '0;
            r_aborted    <= 1'b0;
         end else begin
            if (sample_keep)
               r_sample_cnt <= w_cnt_inc;
            if (w_abort_set)
               r_aborted <= 1'b1;
         end
      end
   end

   assign samplerctrl_sampler_en = r_en;
   assign busy                   = r_busy;
   assign done                   = r_done;
   assign status_aborted         = r_aborted;
   assign sample_cnt             = r_sample_cnt;

endmodule

// File: tb/tb_samplerctrl.sv
// tb/tb_samplerctrl.sv - self-checking bench for samplerctrl
// Cycle model of a capture compared every negedge, plus literal scenario checks.
module tb_samplerctrl;
   localparam int SETTLE = 4;
   localparam int TO     = 8;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        start   = 1'b0;
   logic        abort_i = 1'b0;
   logic        valid   = 1'b0;
   logic [15:0] cfg     = '0;
   logic        en, keep, busy, done, st_ab, st_to;
   logic [15:0] cnt;

   samplerctrl #(.CNT_W(16), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)) dut (
      .clk_sampler                        (clk),
      .rst_sampler_n_sync                 (rst_n),
      .startsync_samplerctrl_start_r_sync (start),
      .cfg_num_samples                    (cfg),
      .abort                              (abort_i),
      .sampler_valid                      (valid),
      .samplerctrl_sampler_en             (en),
      .sample_keep                        (keep),
      .busy                               (busy),
      .done                               (done),
      .status_aborted                     (st_ab),
      .status_timeout                     (st_to),
      .sample_cnt                         (cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int en_cyc  = 0;
   int done_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a capture is "cycles since start" plus count; run phase begins after SETTLE cycles
   bit          m_prev = 0, m_seen_low = 0, m_active = 0, m_fin = 0;
   int          m_pos = 0, m_idle = 0;
   logic [15:0] m_target = '0, e_cnt = '0;
   bit          e_en = 0, e_busy = 0, e_done = 0, e_ab = 0, e_to = 0;

   always @(posedge clk or negedge rst_n) begin : model
      bit evt, mk;
      if (!rst_n) begin
         m_prev = 0; m_seen_low = 0; m_active = 0; m_fin = 0; m_pos = 0; m_idle = 0;
         m_target = '0; e_cnt = '0; e_en = 0; e_busy = 0; e_done = 0; e_ab = 0; e_to = 0;
      end else begin
         evt = start && !m_prev && m_seen_low;
         mk  = m_active && (m_pos >= SETTLE) && valid;
         m_seen_low = m_seen_low || !start;
         m_prev = start;
         e_done = m_fin;
         if (m_fin) begin
            m_fin = 0; e_busy = 0;
         end else if (m_active) begin
            if (mk) e_cnt = e_cnt + 16'd1;
            if (mk && e_cnt == m_target) begin
               m_active = 0; m_fin = 1; e_en = 0;
            end else if (abort_i) begin
               e_ab = 1; m_active = 0; m_fin = 1; e_en = 0;
`ifdef SAMPLERCTRL_TIMEOUT_EN
            end else if (m_pos >= SETTLE && !mk && m_idle == TO - 1) begin
               e_to = 1; m_active = 0; m_fin = 1; e_en = 0;
`endif
            end else begin
               if (m_pos >= SETTLE) m_idle = mk ? 0 : m_idle + 1;
               m_pos++;
            end
         end else if (evt) begin
            m_target = cfg; e_cnt = '0; e_ab = 0; e_to = 0; e_busy = 1;
            if (cfg == 16'd0) m_fin = 1;
            else begin m_active = 1; m_pos = 0; m_idle = 0; e_en = 1; end
         end
      end
   end

   always @(negedge clk) begin
      check("en", en, e_en);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("keep", keep, m_active && (m_pos >= SETTLE) && valid);
      check("aborted", st_ab, e_ab);
      check("timeout", st_to, e_to);
      check("sample_cnt", cnt, e_cnt);
      if (en === 1'b1) en_cyc++;
      if (done === 1'b1) done_cyc++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_cnt(input logic [15:0] v);
      int k;
      k = 0;
      while (cnt !== v && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("wait_cnt_bound", k < 100, 1);
      #1;
   endtask

   task automatic wait_done_state();
      int k;
      k = 0;
      while (!(busy === 1'b1 && en === 1'b0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("wait_done_bound", k < 100, 1);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit reached");
      $fatal(1);
   end

   initial begin
      int b_en, b_done;
      tick(2);
      check("rst_en", en, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", cnt, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      tick(2);

      // cfg=3, valid always high
      cfg = 16'd3; valid = 1'b1; b_en = en_cyc; b_done = done_cyc;
      start = 1'b1;
      tick(14);
      check("t1_en_cycles", en_cyc - b_en, 7);
      check("t1_done_pulses", done_cyc - b_done, 1);
      check("t1_cnt", cnt, 3);
      check("t1_aborted", st_ab, 0);
      start = 1'b0; valid = 1'b0;
      tick(2);

      // cfg=0: done two cycles after start
      cfg = 16'd0; b_en = en_cyc; b_done = done_cyc;
      start = 1'b1;
      @(negedge clk); check("t2_done_c0", done, 0);
      tick(1); @(negedge clk); check("t2_done_c1", done, 0);
      tick(1); @(negedge clk); check("t2_done_c2", done, 1);
      tick(2);
      check("t2_en_cycles", en_cyc - b_en, 0);
      check("t2_cnt", cnt, 0);
      check("t2_done_pulses", done_cyc - b_done, 1);
      start = 1'b0;
      tick(2);

      // cfg=10, abort after 2 kept samples; cfg change after latch ignored
      cfg = 16'd10; valid = 1'b1; start = 1'b1;
      tick(1);
      cfg = 16'd2;
      wait_cnt(16'd2);
      valid = 1'b0; abort_i = 1'b1;
      tick(1);
      abort_i = 1'b0;
      @(negedge clk);
      check("t3_done_state_busy", busy, 1);
      check("t3_done_state_en", en, 0);
      tick(1); @(negedge clk);
      check("t3_done", done, 1);
      check("t3_aborted", st_ab, 1);
      check("t3_cnt", cnt, 2);
      tick(2);

      // cfg=10, abort on the 10th sample: completion wins
      cfg = 16'd10; start = 1'b0;
      tick(1);
      start = 1'b1; valid = 1'b1;
      tick(1);
      wait_cnt(16'd9);
      abort_i = 1'b1;
      tick(1);
      abort_i = 1'b0;
      tick(1); @(negedge clk);
      check("t4_done", done, 1);
      check("t4_cnt", cnt, 10);
      check("t4_aborted", st_ab, 0);
      tick(6);
      check("t4_held_start_idle", busy, 0);

      // edge during RUN ignored, fresh edge after IDLE starts a second capture
      cfg = 16'd4; start = 1'b0;
      tick(1);
      b_done = done_cyc; start = 1'b1;
      tick(6);
      start = 1'b0;
      tick(1);
      start = 1'b1;
      tick(12);
      check("t5_one_capture", done_cyc - b_done, 1);
      check("t5_cnt", cnt, 4);
      start = 1'b0;
      tick(1);
      b_done = done_cyc; start = 1'b1;
      tick(14);
      check("t5_second_capture", done_cyc - b_done, 1);

      // start edge landing in DONE is lost
      start = 1'b0;
      tick(1);
      b_done = done_cyc; start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_done_state();
      start = 1'b1;
      tick(8);
      check("t6_lost_start_busy", busy, 0);
      check("t6_done_pulses", done_cyc - b_done, 1);
      start = 1'b0;
      tick(1);

      // reset in RUN with start held high
      cfg = 16'd5; valid = 1'b1; start = 1'b1;
      tick(1);
      wait_cnt(16'd1);
      rst_n = 1'b0; b_done = done_cyc;
      tick(1); @(negedge clk);
      check("t7_rst_en", en, 0);
      check("t7_rst_busy", busy, 0);
      check("t7_rst_cnt", cnt, 0);
      check("t7_rst_keep", keep, 0);
      tick(1);
      rst_n = 1'b1;
      tick(6);
      check("t7_no_restart", busy, 0);
      check("t7_no_done", done_cyc - b_done, 0);
      start = 1'b0;
      tick(1);
      start = 1'b1;
      tick(3);
      check("t7_fresh_edge", busy, 1);
      tick(14);
      check("t7_cnt", cnt, 5);

      // no sampler_valid in RUN
      start = 1'b0; valid = 1'b0; cfg = 16'd5;
      tick(1);
      b_done = done_cyc; start = 1'b1;
      tick(16);
`ifdef SAMPLERCTRL_TIMEOUT_EN
      check("t8_timeout", st_to, 1);
      check("t8_done", done_cyc - b_done, 1);
      check("t8_busy", busy, 0);
`else
      check("t8_still_busy", busy, 1);
      check("t8_still_en", en, 1);
      check("t8_no_done", done_cyc - b_done, 0);
      abort_i = 1'b1;
      tick(1);
      abort_i = 1'b0;
      tick(3);
      check("t8_aborted", st_ab, 1);
`endif
      check("t8_cnt", cnt, 0);
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
